// File: rtl/rr_grant_arbiter_pkg.sv
// rtl/rr_grant_arbiter_pkg.sv - shared types and one-hot helpers for rr_grant_arbiter
package rr_grant_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } rr_grant_state_t;

    // Vectors are carried at the 32-bit maximum width; callers cast to PORTS.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int ports);
        logic [31:0] r;
        r = v << 1;
        if (v[ports-1]) begin
            r = 32'd1;
        end
        return r;
    endfunction

    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_select.sv
// rtl/rr_grant_arbiter_select.sv - combinational round-robin winner select (module rr_priority_select)
module rr_priority_select
    import rr_grant_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] prio,
    output logic [PORTS-1:0] winner_one_hot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_request
);

    // Low copy keeps only bits at/above prio; the high copy supplies the wrap.
    logic [2*PORTS-1:0] dreq;
    assign dreq = {request, request & ~(prio - PORTS'(1))};

    always_comb begin
        logic found;
        found          = 1'b0;
        winner_one_hot = '0;
        for (int i = 0; i < 2*PORTS; i++) begin
            if (!found && dreq[i]) begin
                found                      = 1'b1;
                winner_one_hot[i % PORTS]  = 1'b1;
            end
        end
    end

    assign winner_idx  = IDX_W'(onehot_to_idx(32'(winner_one_hot)));
    assign any_request = |request;

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin grant arbiter; RR_GRANT_ARBITER_LOCK_EN enables post-handshake lock
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic             grant_ready,
    input  logic             release_lock,
    output logic             grant_valid,
    output logic [PORTS-1:0] grant_one_hot,
    output logic [IDX_W-1:0] grant_idx
);

    rr_grant_state_t  state, state_next;
    logic [PORTS-1:0] prio, prio_next, prio_rot, arb_prio;
    logic             valid_next;
    logic [PORTS-1:0] one_hot_next;
    logic [IDX_W-1:0] idx_next;
    logic [PORTS-1:0] win_one_hot;
    logic [IDX_W-1:0] win_idx;
    logic             any_request;

    assign prio_rot = PORTS'(rotl1(32'(grant_one_hot), PORTS));

    rr_priority_select #(.PORTS(PORTS), .IDX_W(IDX_W)) u_select (
        .request        (request),
        .prio           (arb_prio),
        .winner_one_hot (win_one_hot),
        .winner_idx     (win_idx),
        .any_request    (any_request)
    );

`ifndef RR_GRANT_ARBITER_LOCK_EN
    logic unused_release;
    assign unused_release = release_lock;
`endif

    always_comb begin
        logic do_arb;
        state_next   = state;
        prio_next    = prio;
        arb_prio     = prio;
        valid_next   = grant_valid;
        one_hot_next = grant_one_hot;
        idx_next     = grant_idx;
        do_arb       = 1'b0;
        case (state)
            ARB: do_arb = 1'b1;
            GRANT: begin
                if (grant_ready) begin
                    // The accepted winner drops to lowest priority, effective immediately.
                    prio_next = prio_rot;
                    arb_prio  = prio_rot;
`ifdef RR_GRANT_ARBITER_LOCK_EN
                    if (release_lock) begin
                        do_arb = 1'b1;
                    end else begin
                        state_next   = LOCKED;
                        valid_next   = 1'b0;
                        one_hot_next = '0;
                        idx_next     = '0;
                    end
`else
                    do_arb = 1'b1;
`endif
                end
            end
`ifdef RR_GRANT_ARBITER_LOCK_EN
            LOCKED: do_arb = release_lock;
`endif
            default: state_next = ARB;
        endcase
        if (do_arb) begin
            if (any_request) begin
                state_next   = GRANT;
                valid_next   = 1'b1;
                one_hot_next = win_one_hot;
                idx_next     = win_idx;
            end else begin
                state_next   = ARB;
                valid_next   = 1'b0;
                one_hot_next = '0;
                idx_next     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB;
            prio          <= PORTS'(1);
            grant_valid   <= 1'b0;
            grant_one_hot <= '0;
            grant_idx     <= '0;
        end else begin
            state         <= state_next;
            prio          <= prio_next;
            grant_valid   <= valid_next;
            grant_one_hot <= one_hot_next;
            grant_idx     <= idx_next;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter (4-port and 1-port instances)
module tb_rr_grant_arbiter;

`ifdef RR_GRANT_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        int p;
        int st;
        bit valid;
        int idx;
    } mstate_t;

    typedef struct {
        bit          valid;
        logic [31:0] oh;
        int          idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [0:0] req1 = '0;
    logic       grant_ready = 1'b0;
    logic       release_lock = 1'b0;
    logic       gv4, gv1;
    logic [3:0] goh4;
    logic [0:0] goh1;
    logic [1:0] gidx4;
    logic [0:0] gidx1;

    int vectors = 0;
    int miscompares = 0;
    mstate_t m4, m1;
    exp_t q4[$], q1[$];

    always #5 clk = ~clk;

    rr_grant_arbiter #(.PORTS(4)) dut4 (
        .clk(clk), .rst(rst), .request(req), .grant_ready(grant_ready),
        .release_lock(release_lock), .grant_valid(gv4), .grant_one_hot(goh4), .grant_idx(gidx4)
    );

    rr_grant_arbiter #(.PORTS(1)) dut1 (
        .clk(clk), .rst(rst), .request(req1), .grant_ready(grant_ready),
        .release_lock(release_lock), .grant_valid(gv1), .grant_one_hot(goh1), .grant_idx(gidx1)
    );

    // Pointer model: p is the index of the highest-priority requester; st 0=idle,1=granting,2=locked.
    function automatic mstate_t model_step(input mstate_t s, input int n, input bit r,
                                           input logic [31:0] rq, input bit rdy, input bit rl);
        mstate_t o;
        bit arb;
        o = s;
        if (r) begin
            o.p = 0; o.st = 0; o.valid = 0; o.idx = 0;
            return o;
        end
        arb = 0;
        if (s.st == 0) arb = 1;
        else if (s.st == 1 && rdy) begin
            o.p = (s.idx + 1) % n;
            if (LOCK && !rl) begin
                o.st = 2; o.valid = 0; o.idx = 0;
            end else arb = 1;
        end else if (s.st == 2 && rl) arb = 1;
        if (arb) begin
            o.valid = 0; o.idx = 0; o.st = 0;
            for (int k = 0; k < n; k++) begin
                if (!o.valid && rq[(o.p + k) % n]) begin
                    o.valid = 1; o.idx = (o.p + k) % n; o.st = 1;
                end
            end
        end
        return o;
    endfunction

    function automatic exp_t expect_of(input mstate_t s);
        exp_t e;
        e.valid = s.valid;
        e.oh    = s.valid ? (32'd1 << s.idx) : 32'd0;
        e.idx   = s.idx;
        return e;
    endfunction

    task automatic step(input bit r, input logic [3:0] rq, input bit rdy, input bit rl);
        @(posedge clk);
        #1;
        rst = r; req = rq; req1 = rq[0]; grant_ready = rdy; release_lock = rl;
        m4 = model_step(m4, 4, r, 32'(rq), rdy, rl);
        m1 = model_step(m1, 1, r, 32'(rq[0]), rdy, rl);
        q4.push_back(expect_of(m4));
        q1.push_back(expect_of(m1));
    endtask

    initial begin : monitor
        exp_t e4, e1;
        forever begin
            @(posedge clk);
            if (q4.size() > 0 && q1.size() > 0) begin
                e4 = q4.pop_front();
                e1 = q1.pop_front();
                @(negedge clk);
                vectors++;
                if (gv4 !== e4.valid || 32'(goh4) !== e4.oh || int'(gidx4) != e4.idx) begin
                    miscompares++;
                    $display("FAIL grant4 t=%0t actual v=%b oh=%b idx=%0d required v=%b oh=%b idx=%0d",
                             $time, gv4, goh4, gidx4, e4.valid, e4.oh[3:0], e4.idx);
                end
                vectors++;
                if (gv1 !== e1.valid || 32'(goh1) !== e1.oh || int'(gidx1) != e1.idx) begin
                    miscompares++;
                    $display("FAIL grant1 t=%0t actual v=%b oh=%b idx=%0d required v=%b oh=%b idx=%0d",
                             $time, gv1, goh1, gidx1, e1.valid, e1.oh[0], e1.idx);
                end
            end
        end
    end

    initial begin
        m4 = '{p: 0, st: 0, valid: 0, idx: 0};
        m1 = m4;
        // Reset held with all requesting, then all-request rotation.
        step(1, 4'b1111, 0, 0);
        step(1, 4'b1111, 0, 0);
        repeat (6) step(0, 4'b1111, 1, 1'(LOCK));
        // Sparse requests with wrap.
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0010, 0, 0);
        step(0, 4'b0010, 1, 1'(LOCK));
        step(0, 4'b0001, 1, 1'(LOCK));
        step(0, 4'b1001, 1, 1'(LOCK));
        step(0, 4'b0000, 1, 1'(LOCK));
        // Backpressure while requests change underneath a pending grant.
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0011, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 1, 1'(LOCK));
        step(0, 4'b0000, 1, 0);
        // Lock sequence: hold, release later, then release in the handshake cycle.
        step(1, 4'b1111, 0, 0);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 1, 0);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b1111, 0, 1);
        step(0, 4'b1111, 1, 1);
        step(0, 4'b1111, 1, 1);
        step(0, 4'b1111, 0, 0);
        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3);
        end
        repeat (3) @(posedge clk);
        #1;
        if (q4.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain actual pending=%0d required pending=0", q4.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
